control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/sap1_pkg.sv | 78 +++++++
 rtl/ring_counter.sv | 52 +++++
 rtl/control_sequencer.sv | 148 ++++++++++++++
 tb/tb_control_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcodes, one-hot T-state encodings, decoded
// instruction classes and the control-word layout with its idle value.
package sap1_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned T_W  = 6;

  localparam logic [OP_W-1:0] OP_LDA = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  // One-hot T-states, bit 0 = T1
  typedef enum logic [T_W-1:0] {
    ST_T1 = 6'b000001,
    ST_T2 = 6'b000010,
    ST_T3 = 6'b000100,
    ST_T4 = 6'b001000,
    ST_T5 = 6'b010000,
    ST_T6 = 6'b100000
  } t_state_e;

  typedef enum logic [2:0] {
    INS_LDA,
    INS_ADD,
    INS_SUB,
    INS_OUT,
    INS_HLT,
    INS_NOP
  } instr_e;

  // Control word; n_* fields are active-low, the rest active-high
  typedef struct packed {
    logic cp;
    logic ep;
    logic n_lm;
    logic n_ce;
    logic n_li;
    logic n_ei;
    logic n_la;
    logic n_lb;
    logic n_lo;
    logic ea;
    logic su;
    logic eu;
  } ctrl_word_t;

  localparam ctrl_word_t CW_IDLE = '{
    cp:   1'b0,
    ep:   1'b0,
    n_lm: 1'b1,
    n_ce: 1'b1,
    n_li: 1'b1,
    n_ei: 1'b1,
    n_la: 1'b1,
    n_lb: 1'b1,
    n_lo: 1'b1,
    ea:   1'b0,
    su:   1'b0,
    eu:   1'b0
  };

  // Map the opcode nibble to an instruction class; unknown codes are NOPs
  function automatic instr_e decode_op(input logic [OP_W-1:0] op);
    instr_e ins;
    case (op)
      OP_LDA:  ins = INS_LDA;
      OP_ADD:  ins = INS_ADD;
      OP_SUB:  ins = INS_SUB;
      OP_OUT:  ins = INS_OUT;
      OP_HLT:  ins = INS_HLT;
      default: ins = INS_NOP;
    endcase
    return ins;
  endfunction

endpackage

// File: rtl/ring_counter.sv
// One-hot T-state ring, advancing on the falling clock edge.
// Ports:
//   clk       - system clock (state changes on falling edge)
//   clr       - synchronous active-high clear, forces T1
//   hold      - freeze the ring in its current state (halt)
//   end_early - end the machine cycle now: next state is T1
//   t         - current one-hot T-state
module ring_counter
  import sap1_pkg::*;
(
  input  logic     clk,
  input  logic     clr,
  input  logic     hold,
  input  logic     end_early,
  output t_state_e t
);

  t_state_e t_nxt;
  logic     legal;

  // State register
  always_ff @(negedge clk) begin
    if (clr) begin
      t <= ST_T1;
    end else begin
      t <= t_nxt;
    end
  end

  // Next state; any non-one-hot value recovers to T1 even while holding
  always_comb begin
    t_nxt = ST_T1;
    legal = 1'b1;
    case (t)
      ST_T1:   t_nxt = ST_T2;
      ST_T2:   t_nxt = ST_T3;
      ST_T3:   t_nxt = ST_T4;
      ST_T4:   t_nxt = ST_T5;
      ST_T5:   t_nxt = ST_T6;
      ST_T6:   t_nxt = ST_T1;
      default: legal = 1'b0;
    endcase
    if (legal) begin
      if (hold) begin
        t_nxt = t;
      end else if (end_early) begin
        t_nxt = ST_T1;
      end
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 control sequencer: T-state ring plus combinational control-word
// decode from (T, OPCODE), with a registered halt flag.
// Parameters:
//   SKIP_NOP - 1: end the machine cycle after the last non-idle T-state
// Ports:
//   CLK    - system clock, all state changes on the falling edge
//   CLR    - synchronous active-high reset (falling edge)
//   OPCODE - instruction-register upper nibble, valid T4..T6
//   T      - one-hot T-state, T[0]=T1 .. T[5]=T6
//   Cp, Ep, Ea, Su, Eu              - active-high controls
//   nLm, nCE, nLi, nEi, nLa, nLb, nLo - active-low controls
//   HLT    - registered halt flag
module control_sequencer
  import sap1_pkg::*;
#(
  parameter bit SKIP_NOP = 1'b0
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic [OP_W-1:0] OPCODE,
  output logic [T_W-1:0]  T,
  output logic            Cp,
  output logic            Ep,
  output logic            nLm,
  output logic            nCE,
  output logic            nLi,
  output logic            nEi,
  output logic            nLa,
  output logic            nLb,
  output logic            nLo,
  output logic            Ea,
  output logic            Su,
  output logic            Eu,
  output logic            HLT
);

  t_state_e   t_cur;
  instr_e     instr;
  logic       hlt_q;
  logic       halt_now;
  logic       end_early;
  ctrl_word_t cw;

  assign instr    = decode_op(OPCODE);
  assign halt_now = !hlt_q && (t_cur == ST_T4) && (instr == INS_HLT);

  ring_counter u_ring (
    .clk       (CLK),
    .clr       (CLR),
    .hold      (hlt_q | halt_now),
    .end_early (end_early),
    .t         (t_cur)
  );

  // Halt flag: set by HLT in T4, cleared only by CLR
  always_ff @(negedge CLK) begin
    if (CLR) begin
      hlt_q <= 1'b0;
    end else if (halt_now) begin
      hlt_q <= 1'b1;
    end
  end

  // Early end after the last non-idle step; ADD/SUB always use T6
  always_comb begin
    end_early = 1'b0;
    if (SKIP_NOP && !hlt_q) begin
      case (t_cur)
        ST_T4:   end_early = (instr == INS_OUT) || (instr == INS_NOP);
        ST_T5:   end_early = (instr == INS_LDA);
        default: end_early = 1'b0;
      endcase
    end
  end

  // Control-word decode; everything idle while halted
  always_comb begin
    cw = CW_IDLE;
    if (!hlt_q) begin
      case (t_cur)
        ST_T1: begin
          cw.ep   = 1'b1;
          cw.n_lm = 1'b0;
        end
        ST_T2: begin
          cw.cp = 1'b1;
        end
        ST_T3: begin
          cw.n_ce = 1'b0;
          cw.n_li = 1'b0;
        end
        ST_T4: begin
          case (instr)
            INS_LDA, INS_ADD, INS_SUB: begin
              cw.n_ei = 1'b0;
              cw.n_lm = 1'b0;
            end
            INS_OUT: begin
              cw.ea   = 1'b1;
              cw.n_lo = 1'b0;
            end
            default: ;
          endcase
        end
        ST_T5: begin
          case (instr)
            INS_LDA: begin
              cw.n_ce = 1'b0;
              cw.n_la = 1'b0;
            end
            INS_ADD, INS_SUB: begin
              cw.n_ce = 1'b0;
              cw.n_lb = 1'b0;
            end
            default: ;
          endcase
        end
        ST_T6: begin
          case (instr)
            INS_ADD, INS_SUB: begin
              cw.eu   = 1'b1;
              cw.n_la = 1'b0;
              cw.su   = (instr == INS_SUB);
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign T   = t_cur;
  assign HLT = hlt_q;
  assign Cp  = cw.cp;
  assign Ep  = cw.ep;
  assign nLm = cw.n_lm;
  assign nCE = cw.n_ce;
  assign nLi = cw.n_li;
  assign nEi = cw.n_ei;
  assign nLa = cw.n_la;
  assign nLb = cw.n_lb;
  assign nLo = cw.n_lo;
  assign Ea  = cw.ea;
  assign Su  = cw.su;
  assign Eu  = cw.eu;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: two instances (SKIP_NOP=0/1),
// directed vectors with hand-computed T, HLT and control word.
module tb_control_sequencer;

  // Control word order: {Cp,Ep,nLm,nCE,nLi,nEi,nLa,nLb,nLo,Ea,Su,Eu}
  localparam logic [11:0] W_IDLE = 12'h3F8;
  localparam logic [11:0] W_T1   = 12'h5F8;
  localparam logic [11:0] W_T2   = 12'hBF8;
  localparam logic [11:0] W_T3   = 12'h278;
  localparam logic [11:0] W_FET4 = 12'h1B8;
  localparam logic [11:0] W_LDA5 = 12'h2D8;
  localparam logic [11:0] W_ADD5 = 12'h2E8;
  localparam logic [11:0] W_ADD6 = 12'h3D9;
  localparam logic [11:0] W_SUB6 = 12'h3DB;
  localparam logic [11:0] W_OUT4 = 12'h3F4;

  typedef struct {
    bit          sel;
    bit          clr;
    logic [3:0]  op;
    logic [5:0]  t;
    logic        hlt;
    logic [11:0] cw;
  } vec_t;

  typedef struct {
    int          idx;
    bit          sel;
    logic [5:0]  t;
    logic        hlt;
    logic [11:0] cw;
  } exp_t;

  logic        clk;
  logic        clr0, clr1;
  logic [3:0]  opcode;
  logic [5:0]  tq [2];
  logic [1:0]  cp, ep, nlm, nce, nli, nei, nla, nlb, nlo, ea, su, eu, hlt;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  initial clk = 1'b1;
  always #5 clk = ~clk;

  control_sequencer #(.SKIP_NOP(1'b0)) dut0 (
    .CLK(clk), .CLR(clr0), .OPCODE(opcode), .T(tq[0]),
    .Cp(cp[0]), .Ep(ep[0]), .nLm(nlm[0]), .nCE(nce[0]), .nLi(nli[0]),
    .nEi(nei[0]), .nLa(nla[0]), .nLb(nlb[0]), .nLo(nlo[0]),
    .Ea(ea[0]), .Su(su[0]), .Eu(eu[0]), .HLT(hlt[0])
  );

  control_sequencer #(.SKIP_NOP(1'b1)) dut1 (
    .CLK(clk), .CLR(clr1), .OPCODE(opcode), .T(tq[1]),
    .Cp(cp[1]), .Ep(ep[1]), .nLm(nlm[1]), .nCE(nce[1]), .nLi(nli[1]),
    .nEi(nei[1]), .nLa(nla[1]), .nLb(nlb[1]), .nLo(nlo[1]),
    .Ea(ea[1]), .Su(su[1]), .Eu(eu[1]), .HLT(hlt[1])
  );

  function automatic logic [11:0] cw_of(input int d);
    return {cp[d], ep[d], nlm[d], nce[d], nli[d], nei[d],
            nla[d], nlb[d], nlo[d], ea[d], su[d], eu[d]};
  endfunction

  task automatic add(input bit sel, input bit clr, input logic [3:0] op,
                     input logic [5:0] t, input logic h, input logic [11:0] cw);
    vec_t v;
    v.sel = sel; v.clr = clr; v.op = op; v.t = t; v.hlt = h; v.cw = cw;
    vecs.push_back(v);
  endtask

  // Monitor: outputs sampled on the rising edge, mid-cycle
  exp_t m_e;
  logic [11:0] m_cw;
  always @(posedge clk) begin
    if (sb.size() > 0) begin
      m_e  = sb.pop_front();
      m_cw = cw_of(int'(m_e.sel));
      n_vec++;
      if (tq[m_e.sel] !== m_e.t || hlt[m_e.sel] !== m_e.hlt || m_cw !== m_e.cw) begin
        n_fail++;
        $display("FAIL vec%0d dut%0d: got T=%h HLT=%b cw=%h, want T=%h HLT=%b cw=%h",
                 m_e.idx, m_e.sel, tq[m_e.sel], hlt[m_e.sel], m_cw,
                 m_e.t, m_e.hlt, m_e.cw);
      end
    end
  end

  initial begin
    exp_t e;
    clr0   = 1'b1;
    clr1   = 1'b1;
    opcode = 4'h0;

    // LDA with CLR pulse: full ring, nLm low in T1/T4, nLa low in T5
    add(0, 1, 4'h0, 6'h01, 0, W_T1);
    add(0, 0, 4'h0, 6'h01, 0, W_T1);
    add(0, 0, 4'h0, 6'h02, 0, W_T2);
    add(0, 0, 4'h0, 6'h04, 0, W_T3);
    add(0, 0, 4'h0, 6'h08, 0, W_FET4);
    add(0, 0, 4'h0, 6'h10, 0, W_LDA5);
    add(0, 0, 4'h0, 6'h20, 0, W_IDLE);
    add(0, 0, 4'h0, 6'h01, 0, W_T1);
    // SUB: Su only in T6
    add(0, 0, 4'h2, 6'h02, 0, W_T2);
    add(0, 0, 4'h2, 6'h04, 0, W_T3);
    add(0, 0, 4'h2, 6'h08, 0, W_FET4);
    add(0, 0, 4'h2, 6'h10, 0, W_ADD5);
    add(0, 0, 4'h2, 6'h20, 0, W_SUB6);
    add(0, 0, 4'h2, 6'h01, 0, W_T1);
    // ADD
    add(0, 0, 4'h1, 6'h02, 0, W_T2);
    add(0, 0, 4'h1, 6'h04, 0, W_T3);
    add(0, 0, 4'h1, 6'h08, 0, W_FET4);
    add(0, 0, 4'h1, 6'h10, 0, W_ADD5);
    add(0, 0, 4'h1, 6'h20, 0, W_ADD6);
    add(0, 0, 4'h1, 6'h01, 0, W_T1);
    // OUT
    add(0, 0, 4'hE, 6'h02, 0, W_T2);
    add(0, 0, 4'hE, 6'h04, 0, W_T3);
    add(0, 0, 4'hE, 6'h08, 0, W_OUT4);
    add(0, 0, 4'hE, 6'h10, 0, W_IDLE);
    add(0, 0, 4'hE, 6'h20, 0, W_IDLE);
    add(0, 0, 4'hE, 6'h01, 0, W_T1);
    // Undefined opcode 7 behaves as NOP
    add(0, 0, 4'h7, 6'h02, 0, W_T2);
    add(0, 0, 4'h7, 6'h04, 0, W_T3);
    add(0, 0, 4'h7, 6'h08, 0, W_IDLE);
    add(0, 0, 4'h7, 6'h10, 0, W_IDLE);
    add(0, 0, 4'h7, 6'h20, 0, W_IDLE);
    add(0, 0, 4'h7, 6'h01, 0, W_T1);
    // HLT: freeze in T4, idle word even with other opcodes, CLR releases
    add(0, 0, 4'hF, 6'h02, 0, W_T2);
    add(0, 0, 4'hF, 6'h04, 0, W_T3);
    add(0, 0, 4'hF, 6'h08, 0, W_IDLE);
    for (int i = 0; i < 10; i++)
      add(0, 0, (i % 2 == 0) ? 4'h1 : 4'hE, 6'h08, 1, W_IDLE);
    add(0, 1, 4'h0, 6'h08, 1, W_IDLE);
    add(0, 0, 4'h1, 6'h01, 0, W_T1);
    // CLR during T5 of ADD aborts before T6
    add(0, 0, 4'h1, 6'h02, 0, W_T2);
    add(0, 0, 4'h1, 6'h04, 0, W_T3);
    add(0, 0, 4'h1, 6'h08, 0, W_FET4);
    add(0, 1, 4'h1, 6'h10, 0, W_ADD5);
    add(0, 0, 4'h1, 6'h01, 0, W_T1);
    add(0, 0, 4'h1, 6'h02, 0, W_T2);
    // SKIP_NOP=1: OUT ends after T4
    add(1, 0, 4'hE, 6'h01, 0, W_T1);
    add(1, 0, 4'hE, 6'h02, 0, W_T2);
    add(1, 0, 4'hE, 6'h04, 0, W_T3);
    add(1, 0, 4'hE, 6'h08, 0, W_OUT4);
    // ADD still runs all six states
    add(1, 0, 4'h1, 6'h01, 0, W_T1);
    add(1, 0, 4'h1, 6'h02, 0, W_T2);
    add(1, 0, 4'h1, 6'h04, 0, W_T3);
    add(1, 0, 4'h1, 6'h08, 0, W_FET4);
    add(1, 0, 4'h1, 6'h10, 0, W_ADD5);
    add(1, 0, 4'h1, 6'h20, 0, W_ADD6);
    // LDA ends after T5
    add(1, 0, 4'h0, 6'h01, 0, W_T1);
    add(1, 0, 4'h0, 6'h02, 0, W_T2);
    add(1, 0, 4'h0, 6'h04, 0, W_T3);
    add(1, 0, 4'h0, 6'h08, 0, W_FET4);
    add(1, 0, 4'h0, 6'h10, 0, W_LDA5);
    // NOP ends after T4
    add(1, 0, 4'h7, 6'h01, 0, W_T1);
    add(1, 0, 4'h7, 6'h02, 0, W_T2);
    add(1, 0, 4'h7, 6'h04, 0, W_T3);
    add(1, 0, 4'h7, 6'h08, 0, W_IDLE);
    add(1, 0, 4'h7, 6'h01, 0, W_T1);

    // Drive just after each falling edge; the unselected instance sits in reset
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      #1;
      opcode = vecs[i].op;
      clr0   = (vecs[i].sel == 1'b0) ? vecs[i].clr : 1'b1;
      clr1   = (vecs[i].sel == 1'b1) ? vecs[i].clr : 1'b1;
      e.idx = i; e.sel = vecs[i].sel; e.t = vecs[i].t;
      e.hlt = vecs[i].hlt; e.cw = vecs[i].cw;
      sb.push_back(e);
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
